// File: rtl/btle_rx_pkg.sv
// Shared constants, FSM state type and bit-serial helpers for the BLE 1M-PHY receiver.
package btle_rx_pkg;

  localparam int DEF_SAMPLE_PER_SYMBOL           = 8;
  localparam int DEF_GFSK_DEMODULATION_BIT_WIDTH = 16;
  localparam int DEF_LEN_UNIQUE_BIT_SEQUENCE     = 32;
  localparam int DEF_CHANNEL_NUMBER_BIT_WIDTH    = 6;
  localparam int DEF_CRC_STATE_BIT_WIDTH         = 24;

  localparam logic [23:0] CRC_POLY       = 24'h00065B;
  localparam int          WHITEN_LEN     = 7;
  localparam int          WHITEN_TAP_IN  = 3;
  localparam int          WHITEN_TAP_OUT = 4;

  typedef enum logic [2:0] {SEARCH, HEADER, PAYLOAD, CRC, END} rx_state_t;

  // One CRC24 step: fb = crc[23]^bit, shift left, xor poly when fb set.
  function automatic logic [23:0] crc24_next(input logic [23:0] crc, input logic din);
    logic fb;
    fb = crc[23] ^ din;
    return {crc[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'd0);
  endfunction

  // Whitening LFSR step, bit k holds position k: pos0<=pos6, pos4<=pos3^pos6.
  function automatic logic [WHITEN_LEN-1:0] whiten_next(input logic [WHITEN_LEN-1:0] lfsr);
    logic [WHITEN_LEN-1:0] nxt;
    nxt = {lfsr[WHITEN_LEN-2:0], lfsr[WHITEN_LEN-1]};
    nxt[WHITEN_TAP_OUT] = lfsr[WHITEN_TAP_IN] ^ lfsr[WHITEN_LEN-1];
    return nxt;
  endfunction

  // True when a and b differ in at most one bit position.
  function automatic logic within_one_bit(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    x = a ^ b;
    return ((x & (x - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/btle_rx_gfsk_demod.sv
// GFSK hard-decision demodulator: sign of the cross product between the held and the new I/Q sample.
module btle_rx_gfsk_demod
  import btle_rx_pkg::*;
#(
  parameter int W = DEF_GFSK_DEMODULATION_BIT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] i,
  input  logic signed [W-1:0] q,
  input  logic                iq_valid,
  output logic                demod_bit,
  output logic                demod_valid
);

  logic signed [W-1:0] i_prev_r;
  logic signed [W-1:0] q_prev_r;
  logic signed [2*W:0] cross_s;
  logic                bit_s;

  // d = i[n-1]*q[n] - q[n-1]*i[n]; a positive d means counter-clockwise rotation (bit 1).
  always_comb begin
    cross_s = ((2*W+1)'(i_prev_r) * (2*W+1)'(q)) - ((2*W+1)'(q_prev_r) * (2*W+1)'(i));
    bit_s   = ~cross_s[2*W] & (|cross_s);
  end

  // Held sample and registered decision advance only on a sample strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_prev_r    <= {W{1'b0}};
      q_prev_r    <= {W{1'b0}};
      demod_bit   <= 1'b0;
      demod_valid <= 1'b0;
    end else begin
      demod_valid <= iq_valid;
      if (iq_valid) begin
        i_prev_r  <= i;
        q_prev_r  <= q;
        demod_bit <= bit_s;
      end
    end
  end

endmodule

// File: rtl/btle_rx_top.sv
// BLE 1M-PHY receiver: demod, 8-phase access-address search, de-whitening, CRC24 and a 64x8 PDU RAM.
// Define BTLE_RX_AA_TOLERANCE_EN to accept access addresses with one bit error.
module btle_rx_top
  import btle_rx_pkg::*;
#(
  parameter int SAMPLE_PER_SYMBOL           = DEF_SAMPLE_PER_SYMBOL,
  parameter int GFSK_DEMODULATION_BIT_WIDTH = DEF_GFSK_DEMODULATION_BIT_WIDTH,
  parameter int LEN_UNIQUE_BIT_SEQUENCE     = DEF_LEN_UNIQUE_BIT_SEQUENCE,
  parameter int CHANNEL_NUMBER_BIT_WIDTH    = DEF_CHANNEL_NUMBER_BIT_WIDTH,
  parameter int CRC_STATE_BIT_WIDTH         = DEF_CRC_STATE_BIT_WIDTH,
  localparam int PW = $clog2(SAMPLE_PER_SYMBOL)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]     unique_bit_sequence,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0]    channel_number,
  input  logic [CRC_STATE_BIT_WIDTH-1:0]         crc_state_init_bit,
  input  logic signed [GFSK_DEMODULATION_BIT_WIDTH-1:0] i,
  input  logic signed [GFSK_DEMODULATION_BIT_WIDTH-1:0] q,
  input  logic                                   iq_valid,
  output logic                                   hit_flag,
  output logic                                   decode_run,
  output logic                                   decode_end,
  output logic                                   crc_ok,
  output logic [PW-1:0]                          best_phase,
  output logic [6:0]                             payload_length,
  output logic [7:0]                             pdu_octet_mem_data,
  input  logic [5:0]                             pdu_octet_mem_addr
);

  localparam int L = LEN_UNIQUE_BIT_SEQUENCE;

  logic            demod_bit_s;
  logic            demod_valid_s;
  logic [L-1:0]    phase_sr_r [SAMPLE_PER_SYMBOL];
  logic [PW-1:0]   phase_r;
  rx_state_t       state_r;
  logic [WHITEN_LEN-1:0] lfsr_r;
  logic [23:0]     crc_r;
  logic [7:0]      octet_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      byte_idx_r;
  logic [4:0]      crc_cnt_r;
  logic            crc_match_r;
  logic [7:0]      mem_r [64];

  logic [L-1:0]    new_sr_s;
  logic            aa_hit_s;
  logic            tick_s;
  logic            data_bit_s;
  logic [7:0]      new_octet_s;
  logic [4:0]      crc_idx_s;
  logic            crc_bit_ok_s;
  logic            mem_we_s;

  btle_rx_gfsk_demod #(.W(GFSK_DEMODULATION_BIT_WIDTH)) u_demod (
    .clk         (clk),
    .rst         (rst),
    .i           (i),
    .q           (q),
    .iq_valid    (iq_valid),
    .demod_bit   (demod_bit_s),
    .demod_valid (demod_valid_s)
  );

  // Datapath decisions for the current demodulated bit.
  always_comb begin
    new_sr_s     = {demod_bit_s, phase_sr_r[phase_r][L-1:1]};
`ifdef BTLE_RX_AA_TOLERANCE_EN
    aa_hit_s     = within_one_bit(new_sr_s, unique_bit_sequence);
`else
    aa_hit_s     = (new_sr_s == unique_bit_sequence);
`endif
    tick_s       = demod_valid_s && (phase_r == best_phase);
    data_bit_s   = demod_bit_s ^ lfsr_r[WHITEN_LEN-1];
    new_octet_s  = {data_bit_s, octet_r[7:1]};
    crc_idx_s    = 5'd23 - crc_cnt_r;
    crc_bit_ok_s = (data_bit_s == crc_r[crc_idx_s]);
    mem_we_s     = tick_s && (bit_cnt_r == 3'd7) && (byte_idx_r[7:6] == 2'd0) &&
                   ((state_r == HEADER) || (state_r == PAYLOAD));
  end

  // Every sample lands in the shift register of its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= {PW{1'b0}};
      for (int k = 0; k < SAMPLE_PER_SYMBOL; k++) begin
        phase_sr_r[k] <= {L{1'b0}};
      end
    end else if (demod_valid_s) begin
      phase_sr_r[phase_r] <= new_sr_s;
      phase_r             <= phase_r + PW'(1'b1);
    end
  end

  // PDU RAM keeps its contents across reset; octets beyond address 63 are dropped.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[byte_idx_r[5:0]] <= new_octet_s;
    end
  end

  assign pdu_octet_mem_data = mem_r[pdu_octet_mem_addr];

  // Packet FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= SEARCH;
      hit_flag       <= 1'b0;
      decode_run     <= 1'b0;
      decode_end     <= 1'b0;
      crc_ok         <= 1'b0;
      best_phase     <= {PW{1'b0}};
      payload_length <= 7'd0;
      lfsr_r         <= {WHITEN_LEN{1'b0}};
      crc_r          <= 24'd0;
      octet_r        <= 8'd0;
      bit_cnt_r      <= 3'd0;
      byte_idx_r     <= 8'd0;
      crc_cnt_r      <= 5'd0;
      crc_match_r    <= 1'b0;
    end else begin
      hit_flag   <= 1'b0;
      decode_end <= 1'b0;
      case (state_r)
        SEARCH: begin
          if (demod_valid_s && aa_hit_s) begin
            hit_flag    <= 1'b1;
            decode_run  <= 1'b1;
            crc_ok      <= 1'b0;
            best_phase  <= phase_r;
            lfsr_r      <= {channel_number[0], channel_number[1], channel_number[2],
                            channel_number[3], channel_number[4], channel_number[5], 1'b1};
            crc_r       <= crc_state_init_bit[23:0];
            bit_cnt_r   <= 3'd0;
            byte_idx_r  <= 8'd0;
            crc_cnt_r   <= 5'd0;
            crc_match_r <= 1'b1;
            state_r     <= HEADER;
          end
        end
        HEADER: begin
          if (tick_s) begin
            lfsr_r    <= whiten_next(lfsr_r);
            crc_r     <= crc24_next(crc_r, data_bit_s);
            octet_r   <= new_octet_s;
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              byte_idx_r <= byte_idx_r + 8'd1;
              if (byte_idx_r == 8'd1) begin
                payload_length <= new_octet_s[6:0];
                state_r        <= (new_octet_s[6:0] == 7'd0) ? CRC : PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (tick_s) begin
            lfsr_r    <= whiten_next(lfsr_r);
            crc_r     <= crc24_next(crc_r, data_bit_s);
            octet_r   <= new_octet_s;
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              byte_idx_r <= byte_idx_r + 8'd1;
              if (byte_idx_r == ({1'b0, payload_length} + 8'd1)) begin
                state_r <= CRC;
              end
            end
          end
        end
        CRC: begin
          if (tick_s) begin
            lfsr_r      <= whiten_next(lfsr_r);
            crc_match_r <= crc_match_r & crc_bit_ok_s;
            crc_cnt_r   <= crc_cnt_r + 5'd1;
            if (crc_cnt_r == 5'd23) begin
              crc_ok     <= crc_match_r & crc_bit_ok_s;
              decode_end <= 1'b1;
              decode_run <= 1'b0;
              state_r    <= END;
            end
          end
        end
        END: begin
          state_r <= SEARCH;
        end
        default: begin
          state_r <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btle_rx_top.sv
// Randomized scoreboard bench for btle_rx_top: a GFSK modulator plus packet reference model feed expectation queues.
module tb_btle_rx_top;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        unique_bit_sequence;
  logic [5:0]         channel_number;
  logic [23:0]        crc_state_init_bit;
  logic signed [15:0] i;
  logic signed [15:0] q;
  logic               iq_valid;
  logic               hit_flag;
  logic               decode_run;
  logic               decode_end;
  logic               crc_ok;
  logic [2:0]         best_phase;
  logic [6:0]         payload_length;
  logic [7:0]         pdu_octet_mem_data;
  logic [5:0]         pdu_octet_mem_addr;

  btle_rx_top dut (
    .clk                 (clk),
    .rst                 (rst),
    .unique_bit_sequence (unique_bit_sequence),
    .channel_number      (channel_number),
    .crc_state_init_bit  (crc_state_init_bit),
    .i                   (i),
    .q                   (q),
    .iq_valid            (iq_valid),
    .hit_flag            (hit_flag),
    .decode_run          (decode_run),
    .decode_end          (decode_end),
    .crc_ok              (crc_ok),
    .best_phase          (best_phase),
    .payload_length      (payload_length),
    .pdu_octet_mem_data  (pdu_octet_mem_data),
    .pdu_octet_mem_addr  (pdu_octet_mem_addr)
  );

  always #100 clk = ~clk;

  localparam logic [31:0] AA = 32'h8E89BED6;
`ifdef BTLE_RX_AA_TOLERANCE_EN
  localparam bit TOL_HIT = 1'b1;
`else
  localparam bit TOL_HIT = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] phase;
    logic       crc_ok;
    logic [6:0] len;
    logic [7:0] n;
  } pkt_t;

  int errors = 0;
  int checks = 0;
  int cos_tab [16] = '{8000, 7391, 5657, 3062, 0, -3062, -5657, -7391,
                       -8000, -7391, -5657, -3062, 0, 3062, 5657, 7391};
  int ph = 0;
  int sample_cnt = 0;
  logic [2:0] hit_q [$];
  pkt_t       pkt_q [$];
  logic [7:0] oct_q [$];
  logic [7:0] pkt_oct [130];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_sample(input int ii, input int qq);
    i = 16'(ii);
    q = 16'(qq);
    iq_valid = 1'b1;
    @(posedge clk); #1;
    iq_valid = 1'b0;
    repeat ($urandom_range(1, 2)) @(posedge clk);
    #1;
    sample_cnt++;
  endtask

  task automatic hold_sample();
    send_sample(cos_tab[ph], cos_tab[(ph + 12) % 16]);
  endtask

  // Bit 1 rotates the phasor counter-clockwise, bit 0 clockwise, 8 samples per symbol.
  task automatic send_symbol(input int b);
    for (int k = 0; k < 8; k++) begin
      ph = (b != 0) ? (ph + 1) % 16 : (ph + 15) % 16;
      send_sample(cos_tab[ph], cos_tab[(ph + 12) % 16]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iq_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sample_cnt = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hit"}, 32'(hit_flag), 32'd0);
    check({tag, "_run"}, 32'(decode_run), 32'd0);
    check({tag, "_end"}, 32'(decode_end), 32'd0);
    check({tag, "_crc_ok"}, 32'(crc_ok), 32'd0);
    check({tag, "_phase"}, 32'(best_phase), 32'd0);
    check({tag, "_len"}, 32'(payload_length), 32'd0);
  endtask

  task automatic make_packet(input int len);
    pkt_oct[0] = 8'($urandom);
    pkt_oct[1] = {1'($urandom), 7'(len)};
    for (int k = 0; k < len; k++) pkt_oct[2 + k] = 8'($urandom);
  endtask

  // Reference transmitter: CRC over header+payload, append CRC MSB first, whiten, modulate.
  task automatic run_packet(input int delay, input int ch, input logic [23:0] init,
                            input int flip_idx, input int aa_err, input bit exp_hit,
                            input int abort_bits);
    int bits [$];
    int air [$];
    int pos [7];
    int crc, fb, t6, len, n, s0, nbits;
    logic [31:0] aa_tx;
    logic [7:0]  e;
    pkt_t p;
    len = int'(pkt_oct[1][6:0]);
    for (int o = 0; o < len + 2; o++)
      for (int b = 0; b < 8; b++) bits.push_back(int'(pkt_oct[o][b]));
    crc = int'(init);
    foreach (bits[k]) begin
      fb  = ((crc >> 23) & 1) ^ bits[k];
      crc = ((crc << 1) & 32'hFFFFFF) ^ ((fb != 0) ? 32'h65B : 0);
    end
    for (int k = 0; k < 24; k++) bits.push_back((crc >> (23 - k)) & 1);
    pos[0] = 1;
    for (int k = 1; k < 7; k++) pos[k] = (ch >> (6 - k)) & 1;
    foreach (bits[k]) begin
      air.push_back(bits[k] ^ pos[6]);
      t6 = pos[6];
      for (int m = 6; m > 0; m--) pos[m] = pos[m - 1];
      pos[4] = pos[4] ^ t6;
      pos[0] = t6;
    end
    if (flip_idx >= 0) air[flip_idx] = air[flip_idx] ^ 1;
    aa_tx = AA;
    if (aa_err >= 0) aa_tx[aa_err] = ~aa_tx[aa_err];
    channel_number      = 6'(ch);
    crc_state_init_bit  = init;
    unique_bit_sequence = AA;
    for (int k = 0; k < delay; k++) hold_sample();
    for (int k = 0; k < 8; k++) send_symbol(k % 2);
    s0 = sample_cnt;
    if (exp_hit) begin
      hit_q.push_back(3'(s0 % 8));
      if (abort_bits < 0) begin
        n = (len + 2 < 64) ? len + 2 : 64;
        p.phase = 3'(s0 % 8);
        p.crc_ok = (flip_idx < 0);
        p.len = 7'(len);
        p.n = 8'(n);
        pkt_q.push_back(p);
        for (int k = 0; k < n; k++) begin
          e = pkt_oct[k];
          if (flip_idx >= 0 && flip_idx / 8 == k) e[flip_idx % 8] = ~e[flip_idx % 8];
          oct_q.push_back(e);
        end
      end
    end
    for (int k = 0; k < 32; k++) send_symbol(int'(aa_tx[k]));
    nbits = (abort_bits >= 0) ? abort_bits : air.size();
    for (int k = 0; k < nbits; k++) send_symbol(air[k]);
    if (abort_bits >= 0) begin
      do_reset();
    end else begin
      for (int k = 0; k < 40; k++) hold_sample();
    end
  endtask

  // Monitor: pops expectations whenever the DUT reports a hit or a finished packet.
  initial begin
    pkt_t p;
    logic [2:0] ep;
    pdu_octet_mem_addr = 6'd0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && hit_flag === 1'b1) begin
        if (hit_q.size() == 0) begin
          check("unexpected_hit", 32'd1, 32'd0);
        end else begin
          ep = hit_q.pop_front();
          check("hit_phase", 32'(best_phase), 32'(ep));
          check("hit_run", 32'(decode_run), 32'd1);
        end
      end
      if (rst === 1'b0 && decode_end === 1'b1) begin
        if (pkt_q.size() == 0) begin
          check("unexpected_end", 32'd1, 32'd0);
        end else begin
          p = pkt_q.pop_front();
          check("end_crc_ok", 32'(crc_ok), 32'(p.crc_ok));
          check("end_len", 32'(payload_length), 32'(p.len));
          check("end_phase", 32'(best_phase), 32'(p.phase));
          check("end_run", 32'(decode_run), 32'd0);
          for (int k = 0; k < int'(p.n); k++) begin
            pdu_octet_mem_addr = 6'(k);
            #1;
            check($sformatf("ram[%0d]", k), 32'(pdu_octet_mem_data), 32'(oct_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int len;
    rst = 1'b1;
    iq_valid = 1'b0;
    i = 16'sd0;
    q = 16'sd0;
    channel_number = 6'd0;
    crc_state_init_bit = 24'd0;
    unique_bit_sequence = AA;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sample_cnt = 0;
    check_reset_state("reset");

    make_packet(6);
    run_packet(0, 37, 24'h555555, -1, -1, 1'b1, -1);
    run_packet(0, 37, 24'h555555, 16 + 8 * 2 + 3, -1, 1'b1, -1);

    for (int d = 1; d < 8; d++) begin
      len = (d == 3) ? 0 : (d == 5) ? 66 : int'($urandom_range(1, 10));
      make_packet(len);
      run_packet(d, int'($urandom_range(0, 39)), 24'($urandom), -1, -1, 1'b1, -1);
    end

    for (int k = 0; k < 4000; k++)
      send_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
    check("noise_run", 32'(decode_run), 32'd0);

    make_packet(6);
    run_packet(3, 37, 24'h555555, -1, -1, 1'b1, 16 + 8 * 3 + 4);
    check_reset_state("abort");
    run_packet(2, 37, 24'h555555, -1, -1, 1'b1, -1);

    make_packet(4);
    run_packet(1, 10, 24'($urandom), -1, 13, TOL_HIT, -1);

    repeat (200) @(posedge clk);
    check("pending_hits", 32'(hit_q.size()), 32'd0);
    check("pending_packets", 32'(pkt_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
